// File: rtl/timer_multi_if.sv
// Wishbone peripheral bus bundle shared by the timer and its bus master.
//   wb_cyc/wb_stb : cycle and strobe from master
//   wb_we         : write enable
//   wb_sel[3:0]   : byte lane enables for writes
//   wb_adr        : byte address
//   wb_dat_ms     : write data (master to slave)
//   wb_dat_sm     : read data (slave to master)
//   wb_ack/wb_err : single-cycle response from slave
interface wb_bus_t;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_ms;
    logic [31:0] wb_dat_sm;
    logic        wb_ack;
    logic        wb_err;

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_ms,
        output wb_dat_sm, wb_ack, wb_err
    );

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_ms,
        input  wb_dat_sm, wb_ack, wb_err
    );
endinterface

// File: rtl/timer_multi.sv
// Multi-channel prescaled compare timer, wishbone slave.
//   clk     : system clock
//   rstn_i  : asynchronous active-low reset
//   irq_o   : per-channel level interrupt, |(STATUS & MASK) over the channel's two bits
//   wb_bus  : wishbone slave, combinational single-cycle ack/err
// Map per channel c at c*0x10: CNT, CMP, CFG, reserved; then STATUS (W1C) and MASK.
module timer_multi #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned PRSC_W = 8
) (
    input  logic            clk,
    input  logic            rstn_i,
    output logic [N_CH-1:0] irq_o,
    wb_bus_t.slave          wb_bus
);

    localparam int unsigned SW         = 2 * N_CH;
    localparam logic [31:0] STATUS_ADR = 32'(N_CH * 16);
    localparam logic [31:0] MASK_ADR   = 32'(N_CH * 16 + 4);
    localparam logic [31:0] END_ADR    = 32'(N_CH * 16 + 8);

    logic [CNT_W-1:0]  cnt_q  [N_CH];
    logic [CNT_W-1:0]  cmp_q  [N_CH];
    logic [PRSC_W-1:0] prsc_q [N_CH];
    logic [PRSC_W-1:0] pc_q   [N_CH];
    logic [N_CH-1:0]   en_q;
    logic [N_CH-1:0]   mode_q;
    logic [SW-1:0]     status_q;
    logic [SW-1:0]     mask_q;

    // Address decode and bus response
    logic        acc, adr_ok, wr, rd_en, is_ch;
    logic [3:0]  ch_idx;
    logic [1:0]  off;
    logic [31:0] bmask;
    logic [31:0] wdat;

    assign acc    = wb_bus.wb_cyc && wb_bus.wb_stb;
    assign adr_ok = (wb_bus.wb_adr[1:0] == 2'b00) && (wb_bus.wb_adr < END_ADR);
    assign is_ch  = wb_bus.wb_adr < STATUS_ADR;
    assign ch_idx = wb_bus.wb_adr[7:4];
    assign off    = wb_bus.wb_adr[3:2];
    assign wr     = acc && adr_ok && wb_bus.wb_we;
    assign rd_en  = acc && adr_ok && !wb_bus.wb_we;
    assign wdat   = wb_bus.wb_dat_ms;

    assign wb_bus.wb_ack = acc && adr_ok;
    assign wb_bus.wb_err = acc && !adr_ok;

    // Byte-lane mask from wb_sel
    always_comb begin
        bmask = '0;
        for (int b = 0; b < 4; b++) begin
            bmask[8*b +: 8] = {8{wb_bus.wb_sel[b]}};
        end
    end

    // Per-channel write strobes, merged write data, prescaler tick and events
    logic [N_CH-1:0]   wr_cnt, wr_cmp, wr_cfg, tick, hit_m, hit_o;
    logic [N_CH-1:0]   cfg_en, cfg_mode;
    logic [PRSC_W-1:0] cfg_prsc [N_CH];
    logic [CNT_W-1:0]  cnt_w    [N_CH];
    logic [CNT_W-1:0]  cmp_w    [N_CH];
    logic [SW-1:0]     set_ev;

    always_comb begin
        wr_cnt   = '0;
        wr_cmp   = '0;
        wr_cfg   = '0;
        tick     = '0;
        hit_m    = '0;
        hit_o    = '0;
        cfg_en   = '0;
        cfg_mode = '0;
        set_ev   = '0;
        for (int c = 0; c < N_CH; c++) begin
            cfg_prsc[c] = '0;
            cnt_w[c]    = '0;
            cmp_w[c]    = '0;
        end
        for (int c = 0; c < N_CH; c++) begin
            wr_cnt[c]   = wr && is_ch && (ch_idx == 4'(c)) && (off == 2'd0);
            wr_cmp[c]   = wr && is_ch && (ch_idx == 4'(c)) && (off == 2'd1);
            wr_cfg[c]   = wr && is_ch && (ch_idx == 4'(c)) && (off == 2'd2);
            cnt_w[c]    = CNT_W'((32'(cnt_q[c]) & ~bmask) | (wdat & bmask));
            cmp_w[c]    = CNT_W'((32'(cmp_q[c]) & ~bmask) | (wdat & bmask));
            cfg_en[c]   = bmask[0] ? wdat[0] : en_q[c];
            cfg_mode[c] = bmask[1] ? wdat[1] : mode_q[c];
            cfg_prsc[c] = (prsc_q[c] & ~bmask[PRSC_W+7:8]) | (wdat[PRSC_W+7:8] & bmask[PRSC_W+7:8]);
            tick[c]     = en_q[c] && (pc_q[c] == prsc_q[c]);
            hit_m[c]    = tick[c] && (cnt_q[c] == cmp_q[c]);
            hit_o[c]    = tick[c] && (cnt_q[c] != cmp_q[c]) && (cnt_q[c] == {CNT_W{1'b1}});
            set_ev[2*c]   = hit_m[c];
            set_ev[2*c+1] = hit_o[c];
        end
    end

    // Channel state: counter, compare, config, prescaler
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < N_CH; c++) begin
                cnt_q[c]  <= '0;
                cmp_q[c]  <= '0;
                prsc_q[c] <= '0;
                pc_q[c]   <= '0;
            end
            en_q   <= '0;
            mode_q <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (wr_cnt[c])                   cnt_q[c] <= cnt_w[c];
                else if (hit_m[c] || hit_o[c])   cnt_q[c] <= '0;
                else if (tick[c])                cnt_q[c] <= cnt_q[c] + CNT_W'(1);

                if (wr_cmp[c]) cmp_q[c] <= cmp_w[c];

                // Software config write overrides the one-shot auto-disable
                if (wr_cfg[c]) begin
                    en_q[c]   <= cfg_en[c];
                    mode_q[c] <= cfg_mode[c];
                    prsc_q[c] <= cfg_prsc[c];
                end else if (hit_m[c] && mode_q[c]) begin
                    en_q[c] <= 1'b0;
                end

                // Restart the divider on CNT write, enable edge or disable
                if (wr_cnt[c] || !en_q[c] || (wr_cfg[c] && !cfg_en[c])) pc_q[c] <= '0;
                else if (tick[c])                                       pc_q[c] <= '0;
                else                                                    pc_q[c] <= pc_q[c] + PRSC_W'(1);
            end
        end
    end

    // STATUS is W1C with hardware set taking priority; MASK is plain R/W
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            status_q <= '0;
            mask_q   <= '0;
        end else begin
            if (wr && (wb_bus.wb_adr == STATUS_ADR))
                status_q <= (status_q & ~SW'(wdat & bmask)) | set_ev;
            else
                status_q <= status_q | set_ev;
            if (wr && (wb_bus.wb_adr == MASK_ADR))
                mask_q <= SW'((32'(mask_q) & ~bmask) | (wdat & bmask));
        end
    end

    always_comb begin
        irq_o = '0;
        for (int c = 0; c < N_CH; c++) begin
            irq_o[c] = |(status_q[2*c +: 2] & mask_q[2*c +: 2]);
        end
    end

    // Read mux, zero unless a valid read
    logic [31:0] rdata;
    always_comb begin
        rdata = '0;
        if (rd_en) begin
            if (is_ch) begin
                for (int c = 0; c < N_CH; c++) begin
                    if (ch_idx == 4'(c)) begin
                        case (off)
                            2'd0:    rdata = 32'(cnt_q[c]);
                            2'd1:    rdata = 32'(cmp_q[c]);
                            2'd2:    rdata = 32'({prsc_q[c], 6'b0, mode_q[c], en_q[c]});
                            default: rdata = '0;
                        endcase
                    end
                end
            end else if (wb_bus.wb_adr == STATUS_ADR) begin
                rdata = 32'(status_q);
            end else if (wb_bus.wb_adr == MASK_ADR) begin
                rdata = 32'(mask_q);
            end
        end
    end
    assign wb_bus.wb_dat_sm = rdata;

endmodule

// File: tb/tb_timer_multi.sv
// Directed bench for timer_multi: a 32-bit counter instance and an 8-bit one.
module tb_timer_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        cyc0, cyc1, m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_adr, m_dat;
    logic [3:0]  irq0, irq1;

    int n_checks = 0;
    int n_errors = 0;

    wb_bus_t bus0();
    wb_bus_t bus1();

    assign bus0.wb_cyc    = cyc0;
    assign bus0.wb_stb    = cyc0;
    assign bus0.wb_we     = m_we;
    assign bus0.wb_sel    = m_sel;
    assign bus0.wb_adr    = m_adr;
    assign bus0.wb_dat_ms = m_dat;
    assign bus1.wb_cyc    = cyc1;
    assign bus1.wb_stb    = cyc1;
    assign bus1.wb_we     = m_we;
    assign bus1.wb_sel    = m_sel;
    assign bus1.wb_adr    = m_adr;
    assign bus1.wb_dat_ms = m_dat;

    timer_multi #(.N_CH(4), .CNT_W(32), .PRSC_W(8)) dut (
        .clk(clk), .rstn_i(rstn), .irq_o(irq0), .wb_bus(bus0)
    );

    timer_multi #(.N_CH(4), .CNT_W(8), .PRSC_W(8)) dut8 (
        .clk(clk), .rstn_i(rstn), .irq_o(irq1), .wb_bus(bus1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive after negedge, sample mid-cycle, release after posedge
    task automatic bus(input int d, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rd, output logic ack, output logic err);
        @(negedge clk);
        m_we  = we;
        m_adr = adr;
        m_dat = dat;
        m_sel = sel;
        if (d == 0) cyc0 = 1'b1;
        else        cyc1 = 1'b1;
        #1;
        if (d == 0) begin
            rd = bus0.wb_dat_sm; ack = bus0.wb_ack; err = bus0.wb_err;
        end else begin
            rd = bus1.wb_dat_sm; ack = bus1.wb_ack; err = bus1.wb_err;
        end
        @(posedge clk);
        #1;
        cyc0 = 1'b0;
        cyc1 = 1'b0;
        m_we = 1'b0;
    endtask

    task automatic wr(input int d, input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] r;
        logic a, e;
        bus(d, 1'b1, adr, dat, 4'hF, r, a, e);
        check($sformatf("wr_ack_%0d_%02h", d, adr), 32'({e, a}), 32'h1);
    endtask

    task automatic rd(input int d, input logic [31:0] adr, input logic [31:0] exp, input string tag);
        logic [31:0] r;
        logic a, e;
        bus(d, 1'b0, adr, 32'h0, 4'hF, r, a, e);
        check(tag, r, exp);
    endtask

    logic [31:0] r_d;
    logic        r_a, r_e;

    initial begin
        rstn  = 1'b0;
        cyc0  = 1'b0;
        cyc1  = 1'b0;
        m_we  = 1'b0;
        m_sel = 4'h0;
        m_adr = '0;
        m_dat = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_irq", 32'(irq0), 32'h0);
        check("rst_idle_resp", 32'({bus0.wb_err, bus0.wb_ack}), 32'h0);
        check("rst_idle_dat", bus0.wb_dat_sm, 32'h0);
        rd(0, 32'h00, 32'h0, "rst_cnt0");
        @(negedge clk) rstn = 1'b1;
        rd(0, 32'h08, 32'h0, "rst_cfg0");
        rd(0, 32'h40, 32'h0, "rst_status");
        rd(0, 32'h44, 32'h0, "rst_mask");

        // Ch0 periodic, CMP=5, PRSC=0; enable takes effect at edge 0
        wr(0, 32'h04, 32'd5);
        wr(0, 32'h44, 32'h1);
        wr(0, 32'h08, 32'h1);
        repeat (5) @(posedge clk);
        #1;
        check("t1_irq_before_match", 32'(irq0), 32'h0);
        @(posedge clk);
        #1;
        check("t1_irq_on_match", 32'(irq0), 32'h1);
        rd(0, 32'h00, 32'd0, "t1_cnt_restart");
        rd(0, 32'h00, 32'd1, "t1_cnt_after_restart");
        wr(0, 32'h40, 32'h1);
        check("t1_irq_cleared", 32'(irq0), 32'h0);
        rd(0, 32'h40, 32'h0, "t1_status_cleared");
        @(posedge clk);
        #1;
        // W1C in the same cycle as the next match at edge 12: set wins
        wr(0, 32'h40, 32'h1);
        check("t4_race_irq", 32'(irq0), 32'h1);
        rd(0, 32'h40, 32'h1, "t4_race_status");
        wr(0, 32'h40, 32'h1);
        rd(0, 32'h40, 32'h0, "t4_second_clear");
        rd(0, 32'h00, 32'd3, "t1_cnt_period");
        wr(0, 32'h08, 32'h0);

        // Ch1 one-shot, PRSC=3, CMP=2: ticks every 4 cycles, match at edge 12
        wr(0, 32'h14, 32'd2);
        wr(0, 32'h18, 32'h0000_0303);
        repeat (4) @(posedge clk);
        #1;
        rd(0, 32'h10, 32'd1, "t2_cnt_first_tick");
        rd(0, 32'h40, 32'h0, "t2_status_early");
        repeat (5) @(posedge clk);
        #1;
        rd(0, 32'h40, 32'h0, "t2_status_edge11");
        rd(0, 32'h40, 32'h4, "t2_status_match");
        rd(0, 32'h18, 32'h0000_0302, "t2_cfg_en_cleared");
        check("t2_irq_masked", 32'(irq0), 32'h0);
        rd(0, 32'h10, 32'd0, "t2_cnt_zero");
        wr(0, 32'h40, 32'h4);
        repeat (12) @(posedge clk);
        #1;
        rd(0, 32'h40, 32'h0, "t2_no_rematch");
        rd(0, 32'h10, 32'd0, "t2_cnt_stays_zero");

        // 8-bit instance, ch2 wraps from 0xFE
        wr(1, 32'h20, 32'h0000_00FE);
        wr(1, 32'h24, 32'h10);
        wr(1, 32'h28, 32'h1);
        @(posedge clk);
        #1;
        rd(1, 32'h20, 32'h0000_00FF, "t3_cnt_ff");
        rd(1, 32'h20, 32'h0000_0000, "t3_cnt_wrapped");
        rd(1, 32'h40, 32'h0000_0020, "t3_status_ovf");
        check("t3_irq_masked", 32'(irq1), 32'h0);
        wr(1, 32'h44, 32'h20);
        check("t3_irq_unmasked", 32'(irq1), 32'h4);
        wr(1, 32'h20, 32'hABCD_1234);
        rd(1, 32'h20, 32'h0000_0034, "t3_cnt_truncated");
        wr(1, 32'h28, 32'h0);

        // Bus errors and byte-lane writes
        bus(0, 1'b0, 32'h48, 32'h0, 4'hF, r_d, r_a, r_e);
        check("t5_oob_resp", 32'({r_e, r_a}), 32'h2);
        check("t5_oob_dat", r_d, 32'h0);
        bus(0, 1'b1, 32'h48, 32'hFFFF_FFFF, 4'hF, r_d, r_a, r_e);
        check("t5_oob_wr_resp", 32'({r_e, r_a}), 32'h2);
        bus(0, 1'b1, 32'h46, 32'hFFFF_FFFF, 4'hF, r_d, r_a, r_e);
        check("t5_misal_wr_resp", 32'({r_e, r_a}), 32'h2);
        bus(0, 1'b0, 32'h06, 32'h0, 4'hF, r_d, r_a, r_e);
        check("t5_misal_rd_resp", 32'({r_e, r_a}), 32'h2);
        rd(0, 32'h44, 32'h1, "t5_mask_unchanged");
        bus(0, 1'b1, 32'h34, 32'hAABB_CCDD, 4'b0010, r_d, r_a, r_e);
        check("t5_byte_wr_resp", 32'({r_e, r_a}), 32'h1);
        rd(0, 32'h34, 32'h0000_CC00, "t5_byte_cmp");
        wr(0, 32'h3C, 32'hFFFF_FFFF);
        rd(0, 32'h3C, 32'h0, "t5_reserved");

        // Async reset mid-count
        wr(0, 32'h38, 32'h1);
        wr(0, 32'h08, 32'h1);
        rd(0, 32'h30, 32'd1, "t6_cnt3_running");
        check("t6_irq_before_rst", 32'(irq0), 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_irq_in_rst", 32'(irq0), 32'h0);
        rd(0, 32'h30, 32'h0, "t6_rst_cnt3");
        rd(0, 32'h38, 32'h0, "t6_rst_cfg3");
        rd(0, 32'h34, 32'h0, "t6_rst_cmp3");
        rd(0, 32'h40, 32'h0, "t6_rst_status");
        rd(0, 32'h44, 32'h0, "t6_rst_mask");
        @(negedge clk) rstn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rd(0, 32'h30, 32'h0, "t6_cnt3_held");
        rd(0, 32'h00, 32'h0, "t6_cnt0_held");
        // Re-enable ch3 with CMP=0 after reset: matches every tick, CNT stays 0
        wr(0, 32'h38, 32'h1);
        rd(0, 32'h30, 32'h0, "t6_cmp0_cnt_a");
        rd(0, 32'h40, 32'h40, "t6_cmp0_status");
        rd(0, 32'h30, 32'h0, "t6_cmp0_cnt_b");
        check("t6_irq_mask_reset", 32'(irq0), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
